// File: rtl/reg_file_ctrl.sv
// Byte-stream command front-end for the register file: parses write/read commands from UART RX
// and returns read data as two bytes over UART TX.
module reg_file_ctrl #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned RD_TIMEOUT    = 15,
  parameter logic [7:0]  WR_CMD        = 8'hAA,
  parameter logic [7:0]  RD_CMD        = 8'hBB
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [WIDTH-1:0]         RdData,
  input  logic                     RdData_Valid,
  input  logic                     TX_BUSY,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [WIDTH-1:0]         WrData,
  output logic [7:0]               TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CMD_ERR
);

  localparam int unsigned CntW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrLo, StWrHi, StWrExec,
    StRdAddr, StRdReq, StRdWait, StTxLo, StTxHi
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]         wr_data_q, wr_data_d;
  logic [7:0]               lo_q, lo_d;
  logic                     range_ok_q, range_ok_d;
  logic [7:0]               cap_hi_q, cap_hi_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_vld_q, tx_vld_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic                     err_q, err_d;
  logic [15:0]              rd_ext;

  // Zero-extend so the high byte is well defined for any WIDTH in 9..16.
  assign rd_ext = 16'(RdData);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    lo_d       = lo_q;
    range_ok_d = range_ok_q;
    cap_hi_d   = cap_hi_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = tx_vld_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = StWrAddr;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = StRdAddr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrAddr: begin
        if (RX_D_VLD) begin
          addr_d     = RX_P_DATA[ADDRESS_WIDTH-1:0];
          range_ok_d = 32'(RX_P_DATA) < DEPTH;
          state_d    = StWrLo;
        end
      end
      StWrLo: begin
        if (RX_D_VLD) begin
          lo_d    = RX_P_DATA;
          state_d = StWrHi;
        end
      end
      StWrHi: begin
        // Outputs are registered, so the pulse lands in the WR_EXEC cycle.
        if (RX_D_VLD) begin
          wr_data_d = WIDTH'({RX_P_DATA, lo_q});
          wr_en_d   = range_ok_q;
          err_d     = ~range_ok_q;
          state_d   = StWrExec;
        end
      end
      StWrExec: begin
        state_d = StIdle;
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
          if (32'(RX_P_DATA[ADDRESS_WIDTH-1:0]) >= DEPTH) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            rd_en_d = 1'b1;
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (RdData_Valid) begin
          cap_hi_d  = rd_ext[15:8];
          tx_data_d = rd_ext[7:0];
          tx_vld_d  = 1'b1;
          state_d   = StTxLo;
        end else if (cnt_q == CntW'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTxLo: begin
        if (!TX_BUSY) begin
          tx_data_d = cap_hi_q;
          state_d   = StTxHi;
        end
      end
      StTxHi: begin
        if (!TX_BUSY) begin
          tx_vld_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wr_data_q  <= '0;
      lo_q       <= '0;
      range_ok_q <= 1'b0;
      cap_hi_q   <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      lo_q       <= lo_d;
      range_ok_q <= range_ok_d;
      cap_hi_q   <= cap_hi_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = err_q;

endmodule
